adsr_envelope: RTL and testbench
================================

Name: adsr_envelope

Overview:
- Streaming gain stage placed directly downstream of the wave generators (triangle/sine/square ROM oscillators).
- Multiplies each signed sample by an unsigned ADSR envelope level.
- Advances the envelope state machine once per accepted sample, so one accepted sample equals one envelope tick.
- Feeds the mixer / DAC serializer through a ready/valid output register.

Parameters:
- width_p, 12: sample width, signed two's complement, input and output.
- env_width_p, 8: envelope level width, unsigned; full scale env_max = 2^env_width_p - 1.

Ports:
- clk_i  in  1  clock
- reset_ni  in  1  asynchronous active-low reset
- data_i  in  width_p  signed input sample
- valid_i  in  1  input sample valid
- ready_o  out  1  stage can accept a sample
- gate_i  in  1  note-on level (1 = key held)
- attack_rate_i  in  env_width_p  level increment per tick in ATTACK
- decay_rate_i  in  env_width_p  level decrement per tick in DECAY
- sustain_level_i  in  env_width_p  sustain level
- release_rate_i  in  env_width_p  level decrement per tick in RELEASE
- data_o  out  width_p  enveloped signed sample
- valid_o  out  1  data_o valid
- ready_i  in  1  downstream accepts data_o
- env_o  out  env_width_p  current envelope level (debug/metering)
- state_o  out  3  current state encoding: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4

Behaviour:
- Reset (async assert, sync release): state IDLE, env_q=0, valid_o=0, data_o=0; env_o=0, state_o=0.
- Handshake:
  - ready_o = ~valid_o | ready_i.
  - Accept when valid_i & ready_o.
  - On accept: data_o <= product, valid_o <= 1 on the next edge; latency 1 cycle.
  - valid_o clears on ready_i when no new accept occurs in the same cycle.
  - data_o stable while valid_o & ~ready_i.
  - Full throughput: one sample per cycle when ready_i is held high.
- Arithmetic:
  - prod = signed(data_i) * signed({1'b0, env_q}), full width width_p+env_width_p+1.
  - data_o = prod >>> env_width_p (arithmetic shift, floor), then truncate to width_p. No overflow is possible since env_q < 2^env_width_p.
  - Product always uses env_q before this tick's update.
- Envelope tick: occurs only on accept. gate_i and all rate inputs are sampled at the accept. With no accept, state and env_q hold.
- Transitions, evaluated per tick in this priority order:
  - IDLE: env_q=0. gate=1 -> ATTACK.
  - ATTACK:
    - gate=0 -> RELEASE, env_q unchanged.
    - Else env_q = min(env_q+attack_rate, env_max), using a saturating add at env_width_p+1 bits.
    - On reaching env_max -> DECAY.
  - DECAY:
    - gate=0 -> RELEASE.
    - Else env_q = max(env_q-decay_rate, sustain_level_i), with no underflow.
    - On reaching sustain_level_i -> SUSTAIN.
    - If sustain_level_i >= env_q on entry, go to SUSTAIN immediately, with env_q=sustain_level_i.
  - SUSTAIN:
    - env_q = sustain_level_i, tracking live changes.
    - gate=0 -> RELEASE.
  - RELEASE:
    - gate=1 -> ATTACK (retrigger from current env_q, no reset to 0).
    - Else env_q = max(env_q-release_rate, 0).
    - On reaching 0 -> IDLE.
- Rate of 0: level holds in that state indefinitely; gate transitions still apply.
- Reset mid-note: immediate IDLE and env 0; any in-flight valid_o is dropped.
- Simultaneous accept and downstream pop: both happen, and valid_o stays 1.

Optional Feature:
- Macro ADSR_ENVELOPE_ROUND_EN.
- Defined: data_o = (prod + 2^(env_width_p-1)) >>> env_width_p, i.e. round-half-up to nearest.
- Undefined: floor truncation as specified above.
- Envelope state machine identical in both builds.

Test Plan:
- Reset:
  - Drive reset_ni=0 mid-stream with valid_o=1.
  - Required: valid_o=0, data_o=0, env_o=0, state_o=IDLE asynchronously.
  - Required: first accept after release outputs 0.
- Attack:
  - Setup: gate=1, attack=64, decay=0, constant data_i=1000, ready_i=1.
  - Required data_o sequence: 0, 250, 500, 750, 996.
  - Required env_o sequence: 64, 128, 192, 255, with DECAY entered after the 4th tick.
- Decay/sustain:
  - From env 255, decay=50, sustain=100.
  - Required env: 205, 155, 105, 100, then SUSTAIN.
  - Changing sustain to 120 gives env 120 next tick.
- Release and retrigger:
  - From sustain 100, gate=0, release=40.
  - Required env: 100 (RELEASE), 60, 20, 0, then IDLE.
  - Repeat with gate=1 at env 60: next tick is ATTACK starting from 60.
- Signed/rounding: env 255, data_i=-1000.
  - Without macro: data_o=-997.
  - With ADSR_ENVELOPE_ROUND_EN: data_o=-996.
  - data_i=-2048 with env 255: data_o=-2040, no overflow.
- Backpressure:
  - Hold ready_i=0 for 5 cycles with valid_i=1.
  - Required: ready_o=0, data_o stable, env_o frozen (no ticks).
  - On release of backpressure: throughput of 1 sample per cycle with no samples lost or duplicated, checked against a reference model.

Source files
------------

// File: rtl/adsr_envelope.sv
// ADSR envelope gain stage.
//
// Scales each signed input sample by an unsigned envelope level and advances the
// ADSR state machine once per accepted sample (one accept = one envelope tick).
// The enveloped sample is held in a ready/valid output register.
//
// Optional build macro: ADSR_ENVELOPE_ROUND_EN selects round-half-up scaling
// instead of floor scaling. The envelope state machine is the same in both builds.
//
// Ports:
//   clk_i            clock
//   reset_ni         asynchronous active-low reset
//   data_i           signed input sample
//   valid_i          input sample valid
//   ready_o          stage can accept a sample
//   gate_i           note-on level (1 = key held)
//   attack_rate_i    level increment per tick in ATTACK
//   decay_rate_i     level decrement per tick in DECAY
//   sustain_level_i  sustain level
//   release_rate_i   level decrement per tick in RELEASE
//   data_o           enveloped signed sample
//   valid_o          data_o valid
//   ready_i          downstream accepts data_o
//   env_o            current envelope level
//   state_o          IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
module adsr_envelope #(
  parameter int unsigned width_p     = 12,
  parameter int unsigned env_width_p = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic [width_p-1:0]     data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   gate_i,
  input  logic [env_width_p-1:0] attack_rate_i,
  input  logic [env_width_p-1:0] decay_rate_i,
  input  logic [env_width_p-1:0] sustain_level_i,
  input  logic [env_width_p-1:0] release_rate_i,
  output logic [width_p-1:0]     data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [env_width_p-1:0] env_o,
  output logic [2:0]             state_o
);

  localparam int unsigned ProdW = width_p + env_width_p + 1;
  localparam logic [env_width_p-1:0] EnvMax = '1;
  localparam logic signed [ProdW-1:0] RoundBias =
    {{(ProdW - env_width_p){1'b0}}, 1'b1, {(env_width_p - 1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAttack  = 3'd1,
    StDecay   = 3'd2,
    StSustain = 3'd3,
    StRelease = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [env_width_p-1:0] env_q, env_d;
  logic [width_p-1:0]     data_q, data_d;
  logic                   valid_q, valid_d;

  logic accept;

  assign ready_o = ~valid_q | ready_i;
  assign accept  = valid_i & ready_o;

  // Multiply with the envelope level held before this tick's update.
  logic signed [ProdW-1:0] data_ext, env_ext, prod, prod_adj;

  assign data_ext = {{(env_width_p + 1){data_i[width_p-1]}}, data_i};
  assign env_ext  = {{width_p{1'b0}}, 1'b0, env_q};
  assign prod     = data_ext * env_ext;

`ifdef ADSR_ENVELOPE_ROUND_EN
  assign prod_adj = prod + RoundBias;
`else
  assign prod_adj = prod;
`endif

  // The slice below is the arithmetic shift right by env_width_p, truncated.
  logic unused_prod;
  assign unused_prod = ^{prod_adj[ProdW-1], prod_adj[env_width_p-1:0], RoundBias};

  // Envelope arithmetic, one extra bit to catch saturation and underflow.
  logic [env_width_p:0]   att_sum, dec_diff, rel_diff;
  logic                   att_full, dec_floor, rel_zero;
  logic [env_width_p-1:0] att_level;

  assign att_sum   = {1'b0, env_q} + {1'b0, attack_rate_i};
  assign att_full  = att_sum >= {1'b0, EnvMax};
  assign att_level = att_full ? EnvMax : att_sum[env_width_p-1:0];

  assign dec_diff  = {1'b0, env_q} - {1'b0, decay_rate_i};
  // Also covers sustain at or above the current level: snap straight to it.
  assign dec_floor = dec_diff[env_width_p] |
                     (dec_diff[env_width_p-1:0] <= sustain_level_i);

  assign rel_diff  = {1'b0, env_q} - {1'b0, release_rate_i};
  assign rel_zero  = rel_diff[env_width_p] | (rel_diff[env_width_p-1:0] == '0);

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    data_d  = data_q;
    valid_d = valid_q;

    if (accept) begin
      data_d  = prod_adj[env_width_p +: width_p];
      valid_d = 1'b1;

      unique case (state_q)
        StIdle: begin
          // Note-on from idle applies the first attack step on the same tick.
          if (gate_i) begin
            env_d   = att_level;
            state_d = att_full ? StDecay : StAttack;
          end
        end
        StAttack: begin
          if (!gate_i) begin
            state_d = StRelease;
          end else begin
            env_d = att_level;
            if (att_full) state_d = StDecay;
          end
        end
        StDecay: begin
          if (!gate_i) begin
            state_d = StRelease;
          end else if (dec_floor) begin
            env_d   = sustain_level_i;
            state_d = StSustain;
          end else begin
            env_d = dec_diff[env_width_p-1:0];
          end
        end
        StSustain: begin
          env_d = sustain_level_i;
          if (!gate_i) state_d = StRelease;
        end
        StRelease: begin
          // Retrigger keeps the current level rather than restarting from 0.
          if (gate_i) begin
            state_d = StAttack;
          end else if (rel_zero) begin
            env_d   = '0;
            state_d = StIdle;
          end else begin
            env_d = rel_diff[env_width_p-1:0];
          end
        end
        default: begin
          state_d = StIdle;
          env_d   = '0;
        end
      endcase
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      env_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign env_o   = env_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Bench for adsr_envelope: directed ADSR scenarios followed by randomized traffic,
// all checked against an integer reference model of the envelope and scaling rules.
module tb_adsr_envelope;

  localparam int EMax = 255;

  logic        clk_i;
  logic        reset_ni;
  logic [11:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic        gate_i;
  logic [7:0]  attack_rate_i;
  logic [7:0]  decay_rate_i;
  logic [7:0]  sustain_level_i;
  logic [7:0]  release_rate_i;
  logic [11:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic [7:0]  env_o;
  logic [2:0]  state_o;

  adsr_envelope #(
    .width_p     (12),
    .env_width_p (8)
  ) dut (
    .clk_i           (clk_i),
    .reset_ni        (reset_ni),
    .data_i          (data_i),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .gate_i          (gate_i),
    .attack_rate_i   (attack_rate_i),
    .decay_rate_i    (decay_rate_i),
    .sustain_level_i (sustain_level_i),
    .release_rate_i  (release_rate_i),
    .data_o          (data_o),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .env_o           (env_o),
    .state_o         (state_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release.
  int m_st;
  int m_env;
  int m_data;
  bit m_valid;

  int att_data[5] = '{0, 250, 500, 750, 996};
  int att_env[5]  = '{64, 128, 192, 255, 255};
  int dec_env[4]  = '{205, 155, 105, 100};
  int rel_env[4]  = '{100, 60, 20, 0};
  int rel_st[4]   = '{4, 4, 4, 0};

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int scale(input int d, input int e);
    int p;
    int q;
    p = d * e;
`ifdef ADSR_ENVELOPE_ROUND_EN
    p = p + 128;
`endif
    q = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
    return q;
  endfunction

  task automatic model_tick(input bit g);
    int n;
    case (m_st)
      0: if (g) begin
        m_env = m_env + int'(attack_rate_i);
        if (m_env >= EMax) begin m_env = EMax; m_st = 2; end
        else m_st = 1;
      end
      1: if (!g) m_st = 4;
      else begin
        m_env = m_env + int'(attack_rate_i);
        if (m_env >= EMax) begin m_env = EMax; m_st = 2; end
      end
      2: if (!g) m_st = 4;
      else begin
        n = m_env - int'(decay_rate_i);
        if (n <= int'(sustain_level_i)) begin m_env = int'(sustain_level_i); m_st = 3; end
        else m_env = n;
      end
      3: begin
        m_env = int'(sustain_level_i);
        if (!g) m_st = 4;
      end
      default: if (g) m_st = 1;
      else begin
        n = m_env - int'(release_rate_i);
        if (n <= 0) begin m_env = 0; m_st = 0; end
        else m_env = n;
      end
    endcase
  endtask

  task automatic model_reset();
    m_st = 0;
    m_env = 0;
    m_data = 0;
    m_valid = 1'b0;
  endtask

  // Called at a falling edge: drive, predict, clock, check at the next falling edge.
  task automatic step(input bit v, input logic signed [11:0] d, input bit g, input bit rdy);
    bit exp_rdy;
    valid_i = v;
    data_i  = d;
    gate_i  = g;
    ready_i = rdy;
    #1;
    exp_rdy = !m_valid || rdy;
    chk("ready_o", {31'd0, ready_o}, {31'd0, exp_rdy});
    if (v && exp_rdy) begin
      m_data  = scale(int'(d), m_env);
      m_valid = 1'b1;
      model_tick(g);
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    chk("valid_o", {31'd0, valid_o}, {31'd0, m_valid});
    if (m_valid) chk("data_o", $signed(data_o), m_data);
    chk("env_o", {24'd0, env_o}, m_env);
    chk("state_o", {29'd0, state_o}, m_st);
  endtask

  initial begin
    reset_ni = 1'b0;
    data_i = '0;
    valid_i = 1'b0;
    gate_i = 1'b0;
    ready_i = 1'b0;
    attack_rate_i = 8'd64;
    decay_rate_i = 8'd0;
    sustain_level_i = 8'd100;
    release_rate_i = 8'd40;
    model_reset();
    #1;
    chk("rst_valid", {31'd0, valid_o}, 0);
    chk("rst_data", $signed(data_o), 0);
    chk("rst_env", {24'd0, env_o}, 0);
    chk("rst_state", {29'd0, state_o}, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;

    // Attack from idle.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 12'sd1000, 1'b1, 1'b1);
      chk("att_data", $signed(data_o), att_data[i]);
      chk("att_env", {24'd0, env_o}, att_env[i]);
      if (i == 3) chk("att_to_decay", {29'd0, state_o}, 2);
    end

    // Decay to sustain, then live sustain tracking.
    decay_rate_i = 8'd50;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 12'sd1000, 1'b1, 1'b1);
      chk("dec_env", {24'd0, env_o}, dec_env[i]);
    end
    chk("dec_to_sus", {29'd0, state_o}, 3);
    sustain_level_i = 8'd120;
    step(1'b1, 12'sd1000, 1'b1, 1'b1);
    chk("sus_track", {24'd0, env_o}, 120);
    sustain_level_i = 8'd100;
    step(1'b1, 12'sd1000, 1'b1, 1'b1);

    // Release to idle.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 12'sd1000, 1'b0, 1'b1);
      chk("rel_env", {24'd0, env_o}, rel_env[i]);
      chk("rel_state", {29'd0, state_o}, rel_st[i]);
    end

    // Retrigger during release at level 60.
    attack_rate_i = 8'd255;
    decay_rate_i = 8'd255;
    step(1'b1, 12'sd100, 1'b1, 1'b1);
    step(1'b1, 12'sd100, 1'b1, 1'b1);
    step(1'b1, 12'sd100, 1'b0, 1'b1);
    step(1'b1, 12'sd100, 1'b0, 1'b1);
    step(1'b1, 12'sd100, 1'b1, 1'b1);
    chk("retrig_state", {29'd0, state_o}, 1);
    chk("retrig_env", {24'd0, env_o}, 60);

    // Signed scaling at full level.
    step(1'b1, 12'sd100, 1'b1, 1'b1);
    decay_rate_i = 8'd0;
    sustain_level_i = 8'd0;
    step(1'b1, -12'sd1000, 1'b1, 1'b1);
`ifdef ADSR_ENVELOPE_ROUND_EN
    chk("neg1000", $signed(data_o), -996);
`else
    chk("neg1000", $signed(data_o), -997);
`endif
    step(1'b1, -12'sd2048, 1'b1, 1'b1);
    chk("neg2048", $signed(data_o), -2040);

    // Backpressure: nothing accepted, output and level frozen.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 12'sd777, 1'b1, 1'b0);
      chk("bp_ready", {31'd0, ready_o}, 0);
      chk("bp_data", $signed(data_o), -2040);
      chk("bp_env", {24'd0, env_o}, 255);
    end

    // Full-rate stream after backpressure, then randomized traffic.
    for (int i = 0; i < 8; i++) step(1'b1, 12'($urandom_range(0, 4095)), 1'b1, 1'b1);
    for (int i = 0; i < 400; i++) begin
      if (i % 16 == 0) begin
        attack_rate_i = 8'($urandom_range(0, 90));
        decay_rate_i = 8'($urandom_range(0, 60));
        sustain_level_i = 8'($urandom_range(0, 255));
        release_rate_i = 8'($urandom_range(0, 60));
      end
      step($urandom_range(0, 3) != 0, 12'($urandom_range(0, 4095)),
           ($urandom_range(0, 9) != 0) ? gate_i : ~gate_i, $urandom_range(0, 3) != 0);
    end

    // Asynchronous reset with an output pending.
    step(1'b1, 12'sd500, 1'b1, 1'b0);
    chk("pre_rst_valid", {31'd0, valid_o}, 1);
    #2;
    reset_ni = 1'b0;
    #1;
    chk("arst_valid", {31'd0, valid_o}, 0);
    chk("arst_data", $signed(data_o), 0);
    chk("arst_env", {24'd0, env_o}, 0);
    chk("arst_state", {29'd0, state_o}, 0);
    model_reset();
    @(negedge clk_i);
    reset_ni = 1'b1;
    step(1'b1, 12'sd1500, 1'b0, 1'b1);
    chk("post_rst_data", $signed(data_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
